// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_t     scheduler FSM state encoding
//   DEF_*       default parameter values
//   clog2()     width helper usable in parameter expressions
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BSY  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_HOLD_MAX   = 255;

  // Smallest r with 2**r >= v (v >= 2 gives r >= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req     request vector
//   ptr     highest-priority index; search runs ptr, ptr+1, ... wrapping
//   gnt_id  index of the first set request found
//   any     at least one request set (gnt_id is 0 otherwise)
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    int s;
    s      = 0;
    gnt_id = '0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      if (req[IDW'(s)]) begin
        gnt_id = IDW'(s);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx byte transmitter between NUM_REQ requesters.
// Round-robin arbitration per message; grant held until req_last byte
// completes, followed by a GAP_CYCLES idle gap on the line.
//   clk, rst_n   clock, async active-low reset
//   req_valid    per-requester byte valid
//   req_data     byte of requester i at [8*i+7:8*i]
//   req_last     final byte of message (qualified by valid)
//   req_ready    one-hot or zero; byte taken on valid & ready
//   tx_data      byte to uart_tx, stable from tx_start until tx_busy falls
//   tx_start     one-cycle launch pulse to uart_tx
//   tx_busy      uart_tx is serialising
//   grant_id     current/last owner
//   active       message in progress
//   abort        one-cycle pulse when a message is dropped on hold timeout
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter  int HOLD_MAX   = DEF_HOLD_MAX,
  localparam int IDW        = clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 active,
  output logic                 abort
);

  localparam int HW = clog2(HOLD_MAX + 1);
  localparam int GW = clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

  state_t               state, state_d;
  logic [IDW-1:0]       grant_d, rr_ptr, rr_d;
  logic                 active_d, start_d, abort_d, last_flag, last_d;
  logic [NUM_REQ-1:0]   ready_d;
  logic [7:0]           data_d;
  logic [HW-1:0]        hold_cnt, hold_d;
  logic [GW-1:0]        gap_cnt, gap_d;

  logic [IDW-1:0]       arb_id;
  logic                 arb_any;
  logic [IDW-1:0]       next_ptr;
  logic                 sel_valid, sel_last;
  logic [7:0]           sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[{grant_id, 3'b000} +: 8];
  assign next_ptr  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_d  = state;
    grant_d  = grant_id;
    active_d = active;
    ready_d  = '0;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    data_d   = tx_data;
    last_d   = last_flag;
    hold_d   = hold_cnt;
    gap_d    = gap_cnt;
    rr_d     = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d  = arb_id;
          active_d = 1'b1;
          ready_d  = ONE << arb_id;
          hold_d   = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (sel_valid) begin
          data_d  = sel_data;
          last_d  = sel_last;
          // Launch straight away when the core is free so the start lands
          // the cycle after acceptance; otherwise SEND retries.
          start_d = !tx_busy;
          state_d = ST_SEND;
        end else if (hold_cnt >= HOLD_LAST) begin
          abort_d  = 1'b1;
          active_d = 1'b0;
          rr_d     = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          // Only incremented below HOLD_LAST, so it saturates, never wraps.
          hold_d  = hold_cnt + 1'b1;
          ready_d = ONE << grant_id;
        end
      end
      ST_SEND: begin
        if (tx_start)      state_d = ST_WAIT_BSY;
        else if (!tx_busy) start_d = 1'b1;
      end
      ST_WAIT_BSY: begin
        if (tx_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_flag) begin
            active_d = 1'b0;
            rr_d     = next_ptr;
            gap_d    = '0;
            state_d  = ST_GAP;
          end else begin
            hold_d  = '0;
            ready_d = ONE << grant_id;
            state_d = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt >= GAP_LAST) state_d = ST_IDLE;
        else                     gap_d   = gap_cnt + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id  <= '0;
      active    <= 1'b0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      abort     <= 1'b0;
      tx_data   <= '0;
      last_flag <= 1'b0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      rr_ptr    <= '0;
    end else begin
      grant_id  <= grant_d;
      active    <= active_d;
      req_ready <= ready_d;
      tx_start  <= start_d;
      abort     <= abort_d;
      tx_data   <= data_d;
      last_flag <= last_d;
      hold_cnt  <= hold_d;
      gap_cnt   <= gap_d;
      rr_ptr    <= rr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int NR  = 4;
  localparam int GAP = 4;
  localparam int HMX = 10;
  localparam int BSY = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] rv = '0, rl = '0;
  logic [8*NR-1:0] rd = '0;
  logic [NR-1:0] req_ready;
  logic [7:0]    tx_data;
  logic          tx_start, tx_busy, active, abort;
  logic [1:0]    grant_id;
  logic          force_busy = 1'b0;
  int            bcnt;

  uart_tx_sched #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .HOLD_MAX(HMX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_data(rd), .req_last(rl),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .abort(abort)
  );

  always #5 clk = ~clk;

  // uart_tx model: busy from the cycle after start, for BSY cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bcnt <= 0;
    else if (tx_start) bcnt <= BSY;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) | force_busy;

  typedef struct packed { logic [7:0] d; logic l; } pb_t;
  typedef struct packed { logic [7:0] d; logic [1:0] g; } exp_t;
  pb_t  pbuf [NR][16];
  int   phead [NR];
  int   ptail [NR];
  logic [NR-1:0] acc = '0;
  exp_t exp_q[$];
  int   vectors = 0, errors = 0, n_start = 0, n_abort = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic enq(input int p, input logic [7:0] d, input logic l);
    pbuf[p][ptail[p]] = {d, l};
    ptail[p]++;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] g);
    exp_q.push_back({d, g});
  endtask

  function automatic bit pend_empty();
    for (int i = 0; i < NR; i++) if (phead[i] != ptail[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle: sample at negedge, retire accepted bytes, score starts,
  // then drive each requester from its buffer.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (acc[i]) phead[i]++;
    if (tx_start) begin
      n_start++;
      chk("start_while_busy", 32'(tx_busy), 0);
      if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e.d));
        chk("grant_at_start", 32'(grant_id), 32'(e.g));
      end
    end
    if (abort) n_abort++;
    for (int i = 0; i < NR; i++) begin
      if (phead[i] != ptail[i]) begin
        rv[i] = 1'b1;
        rd[8*i +: 8] = pbuf[i][phead[i]].d;
        rl[i] = pbuf[i][phead[i]].l;
      end else begin
        rv[i] = 1'b0;
        rl[i] = 1'b0;
      end
      acc[i] = rv[i] & req_ready[i];
    end
  endtask

  task automatic wait_starts(input int target, input string tag);
    int b = 0;
    while (n_start < target && b < 400) begin tick(); b++; end
    chk(tag, n_start, target);
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while (!(exp_q.size() == 0 && !active && pend_empty()) && b < 3000) begin
      tick(); b++;
    end
    chk({tag, "_drain_q"}, exp_q.size(), 0);
    chk({tag, "_drain_active"}, 32'(active), 0);
    repeat (GAP + 2) tick();
  endtask

  function automatic logic [31:0] outs();
    return 32'({req_ready, tx_data, tx_start, grant_id, active, abort});
  endfunction

  initial begin
    int b, lows, rcnt, s0;
    logic saw;
    for (int i = 0; i < NR; i++) begin phead[i] = 0; ptail[i] = 0; end

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_ready", 32'(req_ready), 0);

    // 1: three-byte message on req0, then a second message from req0 alone
    enq(0, 8'h55, 0); enq(0, 8'hAA, 0); enq(0, 8'h0F, 1); enq(0, 8'h77, 1);
    push_exp(8'h55, 0); push_exp(8'hAA, 0); push_exp(8'h0F, 0); push_exp(8'h77, 0);
    tick();                       // valid driven
    tick();                       // IDLE saw valid -> ready
    chk("t1_ready_latency", 32'(req_ready), 32'b0001);
    chk("t1_active", 32'(active), 1);
    tick();
    chk("t1_start_latency", n_start, 1);
    wait_starts(3, "t1_three_starts");
    b = 0;
    while (active && b < 500) begin tick(); b++; end
    chk("t1_msg_end", 32'(active), 0);
    // GAP lasts GAP cycles, then IDLE takes one more cycle to regrant.
    lows = 0;
    while (!active && lows < 50) begin lows++; tick(); end
    chk("t1_active_low_cycles", lows, GAP + 1);
    chk("t1_regrant_id", 32'(grant_id), 0);
    chk("t1_regrant_ready", 32'(req_ready), 32'b0001);
    drain("t1");
    chk("t1_start_count", n_start, 4);

    // 2: all four valid from reset, two rounds of 1-byte messages
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      enq(i, 8'(8'h10 + i), 1); enq(i, 8'(8'h20 + i), 1);
    end
    for (int i = 0; i < NR; i++) push_exp(8'(8'h10 + i), 2'(i));
    for (int i = 0; i < NR; i++) push_exp(8'(8'h20 + i), 2'(i));
    drain("t2");

    // 3: req1/req3 arrive during req2's message; search resumes at 3
    s0 = n_start;
    enq(2, 8'h31, 0); enq(2, 8'h32, 0); enq(2, 8'h33, 1);
    push_exp(8'h31, 2); push_exp(8'h32, 2); push_exp(8'h33, 2);
    push_exp(8'h51, 3); push_exp(8'h41, 1);
    wait_starts(s0 + 1, "t3_first_start");
    enq(1, 8'h41, 1); enq(3, 8'h51, 1);
    saw = 1'b0; b = 0;
    while (active && b < 500) begin saw |= req_ready[1] | req_ready[3]; tick(); b++; end
    chk("t3_no_ready_midmsg", 32'(saw), 0);
    drain("t3");

    // 4: req1 sends one non-final byte then goes quiet -> abort
    s0 = n_start;
    enq(1, 8'h61, 0);
    push_exp(8'h61, 1);
    wait_starts(s0 + 1, "t4_first_start");
    rcnt = 0; b = 0;
    while (!abort && b < 300) begin tick(); b++; if (!abort && req_ready[1]) rcnt++; end
    chk("t4_abort_seen", 32'(abort), 1);
    chk("t4_hold_cycles", rcnt, HMX);
    chk("t4_ready_dropped", 32'(req_ready), 0);
    chk("t4_inactive", 32'(active), 0);
    repeat (20) tick();
    chk("t4_abort_count", n_abort, 1);
    chk("t4_no_more_starts", n_start, s0 + 1);
    // rr_ptr now 2: ports 0..2 contend, 2 first, then wrap to 0, then 1
    enq(0, 8'h70, 1); enq(1, 8'h71, 1); enq(2, 8'h72, 1);
    push_exp(8'h72, 2); push_exp(8'h70, 0); push_exp(8'h71, 1);
    drain("t4");

    // 5: core busy when the byte is accepted
    s0 = n_start;
    force_busy = 1'b1;
    enq(3, 8'h5A, 1);
    push_exp(8'h5A, 3);
    repeat (15) tick();
    chk("t5_no_start_while_busy", n_start, s0);
    chk("t5_data_latched", 32'(tx_data), 32'h5A);
    force_busy = 1'b0;
    wait_starts(s0 + 1, "t5_start_after_busy");
    drain("t5");
    chk("t5_single_pulse", n_start, s0 + 1);

    // 6: reset during WAIT_DONE, pending req0 granted after release
    enq(0, 8'h66, 1);
    push_exp(8'h66, 0);
    s0 = n_start;
    wait_starts(s0 + 1, "t6_start");
    repeat (5) tick();
    chk("t6_active_before_rst", 32'(active), 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_outputs", outs(), 0);
    enq(0, 8'h67, 1);
    push_exp(8'h67, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_ready_after_release", 32'(req_ready), 32'b0001);
    chk("t6_grant_after_release", 32'(grant_id), 0);
    drain("t6");
    chk("t6_abort_count", n_abort, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
